vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Downstream consumer of the sprite pixel loader's 24-bit RGB stream.
- Buffers incoming pixels in a small FIFO and generates VGA raster timing (HSYNC, VSYNC, DE).
- Pops one pixel per active-area clock and drives registered RGB to the video DAC / HDMI encoder.
- CLK is the pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW
- UNDERRUN_RGB, 24'h000000, colour driven on an active pixel when the FIFO is empty

Ports:
- CLK  in  1  pixel clock
- RESET  in  1  synchronous, active-high reset
- PIX_DATA  in  24  RGB pixel from the loader, {R[23:16],G[15:8],B[7:0]}
- PIX_VALID  in  1  PIX_DATA valid this cycle
- PIX_READY  out  1  FIFO can accept a pixel
- HSYNC  out  1  horizontal sync, active low
- VSYNC  out  1  vertical sync, active low
- DE  out  1  display enable (active area)
- RGB  out  24  pixel to display
- FRAME_START  out  1  one-cycle pulse, first active pixel of a frame
- UNDERRUN  out  1  sticky flag: an active pixel found the FIFO empty

Behaviour:
- Reset (synchronous, active-high; clock CLK):
  - h_cnt=0, v_cnt=0.
  - FIFO empty, PIX_READY=1.
  - HSYNC=1, VSYNC=1, DE=0, RGB=0, FRAME_START=0, UNDERRUN=0.
- Raster counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - h_cnt increments every clock and wraps at H_TOTAL-1 to 0; v_cnt increments on that wrap and wraps at V_TOTAL-1 to 0.
  - Counter widths derived with $clog2 from the totals.
- Decode (combinational on counters):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Output latency: all outputs are registered, 1 clock after the counter state.
  - HSYNC=~hs, VSYNC=~vs, DE=active.
  - FRAME_START=1 when h_cnt==0 && v_cnt==0.
- FIFO push:
  - Occurs when PIX_VALID && PIX_READY.
  - PIX_READY = !full, evaluated before any same-cycle pop.
  - When full, a push is not accepted even if a pop occurs that cycle.
  - Upstream must hold PIX_DATA/PIX_VALID until accepted.
- FIFO pop:
  - Occurs when active && !empty; the popped word is registered into RGB with the DE registration.
  - If active && empty: RGB<=UNDERRUN_RGB, no pop, UNDERRUN<=1.
  - If !active: RGB<=0, no pop.
- Simultaneous push/pop:
  - Not full and not empty: both occur, occupancy unchanged.
  - Empty with push during an active pixel: underrun colour is output, the pushed word is stored, occupancy becomes 1 (no fall-through).
- UNDERRUN is sticky until the cycle FRAME_START is registered, where it clears. An underrun in that same cycle sets it: set wins.
- Pointers: FIFO_AW+1 bits. Full when the MSBs differ and the rest are equal; empty when all bits are equal. Natural binary wrap.
- Frame alignment:
  - The block does not resynchronise upstream.
  - The upstream loader restarts its address at frame boundaries, relying on FRAME_START.
- Mid-frame RESET: counters, FIFO and flags return to reset values the next clock; the raster restarts at h=0, v=0.

Optional Feature:
- Macro: VGA_SCANOUT_TEST_PATTERN_EN.
- Defined: adds input port TP_SEL (1 bit). While TP_SEL=1:
  - Active pixels show 8 vertical colour bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black (channel values 8'hFF/8'h00).
  - The FIFO is not popped and UNDERRUN is not set.
  - Push and PIX_READY behave normally.
- Undefined: TP_SEL port and bar logic absent; RGB always comes from the FIFO or UNDERRUN_RGB.

Decomposition:
- Shared package vga_pkg:
  - Default 640x480 timing constants.
  - RGB width constant (24).
  - Colour-bar constants.
- Sub-module pixel_fifo:
  - Parameterised synchronous FIFO (width 24, FIFO_AW).
  - Ports: push/pop/din/dout/full/empty.
  - Instantiated once; reusable elsewhere in the design.

Test Plan:
- Reset, then free-run one frame with PIX_VALID=0:
  - HSYNC low for 96 clocks starting 656 clocks into each line.
  - VSYNC low on lines 490-491.
  - 800x525 = 420000 clocks per frame.
  - UNDERRUN=1 from the first active pixel.
- Prefill 16 pixels (values 1..16), PIX_VALID held high:
  - PIX_READY drops after the 16th accept.
  - The first active line outputs RGB 1,2,...,16 in order.
  - No UNDERRUN while the source keeps pace.
- Continuous source (one pixel per clock, incrementing):
  - DE high for exactly 640 clocks per line.
  - RGB follows DE by 0 extra cycles (same registered edge).
  - FRAME_START pulses once per 420000 clocks.
- Starve the FIFO mid-line (PIX_VALID=0 for 20 active clocks):
  - RGB=UNDERRUN_RGB on those clocks; UNDERRUN sets.
  - UNDERRUN clears at the next FRAME_START and stays 0 with a healthy source.
- Assert RESET for 1 clock at h=300, v=200:
  - Next clock h=0, v=0; FIFO empty; PIX_READY=1.
  - HSYNC/VSYNC=1, DE=0, RGB=0.
- With VGA_SCANOUT_TEST_PATTERN_EN defined, TP_SEL=1:
  - Pixels 0-79 = FFFFFF, 80-159 = FFFF00, ..., 560-639 = 000000.
  - FIFO occupancy unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared video definitions: default 640x480 timing, RGB pixel format and colour-bar palette.
// Pure declarations; no clocked logic, so no latency or flow-control semantics here.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int RGB_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bar order left to right across the active line.
  typedef enum logic [2:0] {
    BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
    BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
  } bar_e;

  localparam logic [7:0] CH_ON  = 8'hFF;
  localparam logic [7:0] CH_OFF = 8'h00;

  function automatic rgb_t bar_colour(input bar_e bar);
    rgb_t c;
    case (bar)
      BAR_WHITE:   c = '{CH_ON,  CH_ON,  CH_ON };
      BAR_YELLOW:  c = '{CH_ON,  CH_ON,  CH_OFF};
      BAR_CYAN:    c = '{CH_OFF, CH_ON,  CH_ON };
      BAR_GREEN:   c = '{CH_OFF, CH_ON,  CH_OFF};
      BAR_MAGENTA: c = '{CH_ON,  CH_OFF, CH_ON };
      BAR_RED:     c = '{CH_ON,  CH_OFF, CH_OFF};
      BAR_BLUE:    c = '{CH_OFF, CH_OFF, CH_ON };
      default:     c = '{CH_OFF, CH_OFF, CH_OFF};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO, 2**AW deep; dout shows the head word combinationally (no fall-through on empty).
// Push ignored when full, pop ignored when empty; full/empty reflect stored state only.
module pixel_fifo #(
  parameter int W  = 24,
  parameter int AW = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB tells a full ring apart from an empty one.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (do_push && !RESET) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: buffers the loader's RGB stream and drives raster timing; VGA_SCANOUT_TEST_PATTERN_EN adds TP_SEL colour bars.
// Every output is registered one clock after the raster counters; PIX_READY drops only while the FIFO is full.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int               H_ACTIVE     = H_ACTIVE_DEF,
  parameter int               H_FP         = H_FP_DEF,
  parameter int               H_SYNC       = H_SYNC_DEF,
  parameter int               H_BP         = H_BP_DEF,
  parameter int               V_ACTIVE     = V_ACTIVE_DEF,
  parameter int               V_FP         = V_FP_DEF,
  parameter int               V_SYNC       = V_SYNC_DEF,
  parameter int               V_BP         = V_BP_DEF,
  parameter int               FIFO_AW      = 4,
  parameter logic [RGB_W-1:0] UNDERRUN_RGB = 24'h000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [RGB_W-1:0] PIX_DATA,
  input  logic             PIX_VALID,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic             TP_SEL,
`endif
  output logic             PIX_READY,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DE,
  output logic [RGB_W-1:0] RGB,
  output logic             FRAME_START,
  output logic             UNDERRUN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          hs;
  logic          vs;
  logic          frame_first;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [RGB_W-1:0] fifo_dout;

  logic tp_on;
  rgb_t pix_bar;
  rgb_t pix_next;
  logic underrun_hit;

  logic hsync_q;
  logic vsync_q;
  logic de_q;
  logic fs_q;
  logic underrun_q;
  rgb_t rgb_q;

  assign h_last      = (h_cnt == H_LAST);
  assign v_last      = (v_cnt == V_LAST);
  assign active      = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
  assign hs          = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs          = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BPW-1:0] BAR_PX_LAST = BPW'(BAR_W - 1);

  logic [BPW-1:0] bar_px;
  logic [2:0]     bar_idx;

  // Runs in lockstep with h_cnt so bar widths need no divider.
  always_ff @(posedge CLK) begin
    if (RESET || h_last) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_PX_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + BPW'(1);
    end
  end

  assign tp_on   = TP_SEL;
  assign pix_bar = bar_colour(bar_e'(bar_idx));
`else
  assign tp_on   = 1'b0;
  assign pix_bar = '0;
`endif

  // Acceptance depends only on stored occupancy, so a same-cycle pop never frees a slot early.
  assign PIX_READY = !fifo_full;
  assign fifo_push = PIX_VALID && !fifo_full;

  always_comb begin
    pix_next     = '0;
    fifo_pop     = 1'b0;
    underrun_hit = 1'b0;
    if (active) begin
      if (tp_on) begin
        pix_next = pix_bar;
      end else if (!fifo_empty) begin
        pix_next = fifo_dout;
        fifo_pop = 1'b1;
      end else begin
        pix_next     = UNDERRUN_RGB;
        underrun_hit = 1'b1;
      end
    end
  end

  pixel_fifo #(
    .W  (RGB_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (PIX_DATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      hsync_q <= ~hs;
      vsync_q <= ~vs;
      de_q    <= active;
      fs_q    <= frame_first;
      rgb_q   <= pix_next;
      // Frame start clears the flag, but an underrun on that same pixel re-arms it.
      underrun_q <= (underrun_q && !frame_first) || underrun_hit;
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign FRAME_START = fs_q;
  assign RGB         = rgb_q;
  assign UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a shrunken 25x8 raster (16x4 active) with a 16-deep FIFO.
// Table-driven raster vectors plus directed prefill, starvation, mid-frame reset and colour-bar sequences.
module tb_vga_scanout;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int H_TOT = HA + HF + HS + HB;
  localparam int V_TOT = VA + VF + VS + VB;
  localparam logic [23:0] URGB = 24'hABCDEF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [23:0] PIX_DATA = '0;
  logic        PIX_VALID = 1'b0;
  logic        TP_SEL = 1'b0;
  logic        PIX_READY, HSYNC, VSYNC, DE, FRAME_START, UNDERRUN;
  logic [23:0] RGB;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_AW(AW), .UNDERRUN_RGB(URGB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .TP_SEL(TP_SEL),
`endif
    .PIX_READY(PIX_READY), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .RGB(RGB),
    .FRAME_START(FRAME_START), .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] cnt;
    logic        hs, vs, de, fs, und;
    logic [23:0] rgb;
  } vec_t;

  vec_t        vt [16];
  logic [23:0] bar_tab [8];
  logic [23:0] q [$];
  int          n_chk = 0, n_fail = 0;
  int          cnt = -1;
  logic [23:0] next_data = '0;
  logic        exp_und = 1'b0;

  task automatic chk1(input string nm, input logic got, input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cnt=%0d got=%b want=%b", nm, cnt, got, want);
    end
  endtask

  task automatic chk24(input string nm, input logic [23:0] got, input logic [23:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cnt=%0d got=%h want=%h", nm, cnt, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic set_src(input logic on);
    PIX_VALID = on;
    PIX_DATA  = next_data;
  endtask

  // One pixel clock with a queue scoreboard: expected outputs come from cnt and the bench's own FIFO model.
  task automatic tick();
    logic        acc, act, tp, hs_e, vs_e;
    logic [23:0] pushed, exp_rgb;
    int          h, v;
    acc    = PIX_VALID && (q.size() < DEPTH);
    pushed = PIX_DATA;
    tp     = TP_SEL;
    @(posedge CLK);
    #1;
    cnt++;
    h    = cnt % H_TOT;
    v    = (cnt / H_TOT) % V_TOT;
    act  = (h < HA) && (v < VA);
    hs_e = !((h >= HA + HF) && (h < HA + HF + HS));
    vs_e = !((v >= VA + VF) && (v < VA + VF + VS));
    if (h == 0 && v == 0) exp_und = 1'b0;
    exp_rgb = '0;
    if (act) begin
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      if (tp) exp_rgb = bar_tab[h / (HA / 8)];
      else
`endif
      if (q.size() > 0) exp_rgb = q.pop_front();
      else begin
        exp_rgb = URGB;
        exp_und = 1'b1;
      end
    end
    if (acc) begin
      q.push_back(pushed);
      next_data = next_data + 24'd1;
    end
    PIX_DATA = next_data;
    chk1("sb_hsync", HSYNC, hs_e);
    chk1("sb_vsync", VSYNC, vs_e);
    chk1("sb_de", DE, act);
    chk1("sb_frame_start", FRAME_START, (h == 0 && v == 0));
    chk24("sb_rgb", RGB, exp_rgb);
    chk1("sb_underrun", UNDERRUN, exp_und);
    chk1("sb_pix_ready", PIX_READY, q.size() < DEPTH);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    PIX_VALID = 1'b0;
    TP_SEL = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    q.delete();
    exp_und = 1'b0;
    cnt = -1;
    chk1("rst_hsync", HSYNC, 1'b1);
    chk1("rst_vsync", VSYNC, 1'b1);
    chk1("rst_de", DE, 1'b0);
    chk24("rst_rgb", RGB, 24'h0);
    chk1("rst_frame_start", FRAME_START, 1'b0);
    chk1("rst_underrun", UNDERRUN, 1'b0);
    chk1("rst_pix_ready", PIX_READY, 1'b1);
  endtask

  task automatic run_to(input int target);
    while (cnt < target) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, vs_low, de_n, fs_n, hs_fall, und_n, urgb_n;
    logic prev_hs;

    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    //          cnt     hs    vs    de    fs    und   rgb
    vt[0]  = '{16'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, URGB};
    vt[1]  = '{16'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, URGB};
    vt[2]  = '{16'd15,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, URGB};
    vt[3]  = '{16'd16,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[4]  = '{16'd18,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[5]  = '{16'd21,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[6]  = '{16'd22,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[7]  = '{16'd24,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[8]  = '{16'd25,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, URGB};
    vt[9]  = '{16'd115, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[10] = '{16'd125, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[11] = '{16'd143, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[12] = '{16'd174, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[13] = '{16'd175, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[14] = '{16'd199, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[15] = '{16'd200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, URGB};

    // Free-running raster with no source.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_to(int'(vt[i].cnt));
      chk1("vec_hsync", HSYNC, vt[i].hs);
      chk1("vec_vsync", VSYNC, vt[i].vs);
      chk1("vec_de", DE, vt[i].de);
      chk1("vec_frame_start", FRAME_START, vt[i].fs);
      chk1("vec_underrun", UNDERRUN, vt[i].und);
      chk24("vec_rgb", RGB, vt[i].rgb);
      chk1("vec_pix_ready", PIX_READY, 1'b1);
    end

    hs_low = 0; vs_low = 0; de_n = 0; fs_n = 0; hs_fall = 0;
    prev_hs = HSYNC;
    repeat (200) begin
      tick();
      if (!HSYNC) hs_low++;
      if (!VSYNC) vs_low++;
      if (DE) de_n++;
      if (FRAME_START) fs_n++;
      if (prev_hs && !HSYNC && (cnt % H_TOT) == HA + HF) hs_fall++;
      prev_hs = HSYNC;
    end
    chk_int("frame_hsync_low_clocks", hs_low, 8 * HS);
    chk_int("frame_hsync_falls_at_18", hs_fall, 8);
    chk_int("frame_vsync_low_clocks", vs_low, VS * H_TOT);
    chk_int("frame_de_clocks", de_n, HA * VA);
    chk_int("frame_start_pulses", fs_n, 1);
    chk1("frame_start_at_400", FRAME_START, 1'b1);

    // Prefill during vertical blanking, then keep the source running.
    do_reset();
    run_to(100);
    next_data = 24'd1;
    set_src(1'b1);
    run_to(115);
    chk1("prefill_ready_after_15", PIX_READY, 1'b1);
    run_to(116);
    chk1("prefill_ready_after_16", PIX_READY, 1'b0);
    run_to(199);
    chk1("prefill_underrun_frame0", UNDERRUN, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk24("prefill_rgb", RGB, 24'(i + 1));
      chk1("prefill_de", DE, 1'b1);
      if (i == 0) chk1("prefill_underrun_cleared", UNDERRUN, 1'b0);
    end
    und_n = 0; de_n = 0;
    repeat (185) begin
      tick();
      if (UNDERRUN) und_n++;
      if (DE) de_n++;
    end
    chk_int("stream_underrun_clocks", und_n, 0);
    chk_int("stream_de_clocks", de_n, HA * VA - 16 + 1);
    chk1("stream_frame_start_400", FRAME_START, 1'b1);

    // Starve the FIFO mid-frame.
    run_to(405);
    set_src(1'b0);
    urgb_n = 0;
    while (cnt < 466) begin
      tick();
      if (DE && RGB == URGB) urgb_n++;
      if (cnt == 429) chk1("starve_underrun_before", UNDERRUN, 1'b0);
      if (cnt == 430) chk1("starve_underrun_set", UNDERRUN, 1'b1);
    end
    chk_int("starve_underrun_pixels", urgb_n, 27);
    set_src(1'b1);
    run_to(599);
    chk1("starve_underrun_sticky", UNDERRUN, 1'b1);
    run_to(600);
    chk1("starve_underrun_cleared", UNDERRUN, 1'b0);
    und_n = 0;
    repeat (200) begin
      tick();
      if (UNDERRUN) und_n++;
    end
    chk_int("recover_underrun_clocks", und_n, 0);

    // Mid-frame reset with counters at h=10, v=2.
    run_to(859);
    do_reset();
    tick();
    chk1("post_rst_frame_start", FRAME_START, 1'b1);
    chk1("post_rst_de", DE, 1'b1);
    chk24("post_rst_rgb_empty", RGB, URGB);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    run_to(16);
    next_data = 24'h000100;
    set_src(1'b1);
    run_to(24);
    TP_SEL = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk24("tp_bar", RGB, bar_tab[i / 2]);
    end
    TP_SEL = 1'b0;
    run_to(50);
    chk24("tp_fifo_untouched", RGB, 24'h000100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
